// File: rtl/trb_pkg.sv
// Shared definitions for the turbo decoder array (input scheduler and output mux).
//   NUM_TURBO_MAX : upper bound on the decoder count
//   TRB_PKT_WORDS : bus words per turbo packet (1024-bit block plus 4 tail bits)
//   trb_idx_t     : decoder index wide enough for NUM_TURBO_MAX decoders
//   sched_st_t    : input scheduler states
package trb_pkg;

    localparam int unsigned NUM_TURBO_MAX = 8;
    localparam int unsigned TRB_PKT_WORDS = 25;
    localparam int unsigned TRB_IDX_W     = $clog2(NUM_TURBO_MAX);

    typedef logic [TRB_IDX_W-1:0] trb_idx_t;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } sched_st_t;

endpackage

// File: rtl/trb_ord_fifo.sv
// Synchronous order FIFO holding decoder indices in packet arrival order.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : write request and data (dropped when full)
//   pop                 : read request (ignored when empty)
//   head                : entry at the head, forced to 0 while empty
//   full, empty         : occupancy flags
module trb_ord_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/trb_in_sched.sv
// Packet-level input scheduler for the multi-decoder turbo array.
// Steers whole packets of PKT_WORDS bus words to a ready decoder chosen
// round-robin, and records each granted decoder index in an order FIFO.
// Optional feature: define TRB_SCHED_TIMEOUT_EN to build a stall watchdog
// that aborts a packet after TIMEOUT stalled cycles and sets err_timeout.
// Ports:
//   clk_bus, rst  : bus clock, synchronous active-high reset
//   bus_en        : upstream word valid (accepted when bus_en & bus_ready)
//   bus_ready     : scheduler can take a word (combinational, XFER only)
//   dec_ready     : per-decoder ready from the bus2st front ends
//   dec_en        : per-decoder word strobe, one cycle after acceptance
//   ord_idx       : decoder index at the head of the order FIFO
//   ord_valid     : order FIFO not empty
//   ord_ready     : pop request from the output mux
//   busy          : packet in flight
//   err_timeout   : sticky stall error
module trb_in_sched
    import trb_pkg::*;
#(
    parameter int unsigned NUM_TURBO = 2,
    parameter int unsigned PKT_WORDS = TRB_PKT_WORDS,
    parameter int unsigned ORD_DEPTH = 8,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                         clk_bus,
    input  logic                         rst,
    input  logic                         bus_en,
    output logic                         bus_ready,
    input  logic [NUM_TURBO-1:0]         dec_ready,
    output logic [NUM_TURBO-1:0]         dec_en,
    output logic [$clog2(NUM_TURBO)-1:0] ord_idx,
    output logic                         ord_valid,
    input  logic                         ord_ready,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_TURBO);
    localparam int unsigned CNT_W = $clog2(PKT_WORDS);

    sched_st_t        state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] wcnt;

    logic [IDX_W-1:0] cand;
    logic             cand_found;
    logic             grant;
    logic             acc;
    logic             stall_abort;
    logic             fifo_full;
    logic             fifo_empty;

    // Round-robin search starting just after the last granted decoder
    always_comb begin : arb_search
        int unsigned j;
        cand       = '0;
        cand_found = 1'b0;
        j          = 0;
        for (int unsigned k = 1; k <= NUM_TURBO; k++) begin
            j = 32'(last) + k;
            if (j >= NUM_TURBO) j = j - NUM_TURBO;
            if (!cand_found && dec_ready[IDX_W'(j)]) begin
                cand_found = 1'b1;
                cand       = IDX_W'(j);
            end
        end
    end

    // Full flag is the pre-pop value, so a same-cycle pop defers the grant by one cycle
    assign grant     = (state == ARB) & cand_found & ~fifo_full;
    assign bus_ready = (state == XFER) & dec_ready[sel];
    assign acc       = bus_en & bus_ready;
    assign busy      = (state == XFER);
    assign ord_valid = ~fifo_empty;

    // Scheduler FSM and registered decoder strobes
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            state  <= ARB;
            sel    <= '0;
            last   <= IDX_W'(NUM_TURBO - 1);
            wcnt   <= '0;
            dec_en <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_TURBO; i++) begin
                dec_en[i] <= acc & (sel == IDX_W'(i));
            end
            case (state)
                ARB: begin
                    if (grant) begin
                        sel   <= cand;
                        last  <= cand;
                        wcnt  <= '0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (acc) begin
                        if (wcnt == CNT_W'(PKT_WORDS - 1)) state <= ARB;
                        else                               wcnt  <= wcnt + CNT_W'(1);
                    end else if (stall_abort) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

`ifdef TRB_SCHED_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT);

    logic [STALL_W-1:0] stall_cnt;
    logic               err_q;

    assign stall_abort = (state == XFER) & ~acc & (stall_cnt == STALL_W'(TIMEOUT - 1));
    assign err_timeout = err_q;

    // Stall watchdog: counts consecutive XFER cycles without an accepted word
    always_ff @(posedge clk_bus) begin
        if (rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else if ((state != XFER) || acc) begin
            stall_cnt <= '0;
        end else if (stall_abort) begin
            stall_cnt <= '0;
            err_q     <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`else
    assign stall_abort = 1'b0;
    assign err_timeout = 1'b0;
`endif

    trb_ord_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORD_DEPTH)
    ) u_ord_fifo (
        .clk       (clk_bus),
        .rst       (rst),
        .push      (grant),
        .push_data (cand),
        .pop       (ord_ready),
        .head      (ord_idx),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
